capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl_pkg.sv | 40 ++++
 rtl/capture_ctrl_trig_cmp.sv | 13 +
 rtl/capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_capture_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/capture_ctrl_pkg.sv
// Shared command codes, state encodings and command decoder
// for the capture controller and the host-link FSM.
package capture_ctrl_pkg;

  localparam logic [31:0] CMD_START = 32'h1111_1111;
  localparam logic [31:0] CMD_STOP  = 32'h0000_0000;

  localparam logic [3:0] OP_SET_MASK  = 4'h2;
  localparam logic [3:0] OP_SET_VAL   = 4'h3;
  localparam logic [3:0] OP_SET_COUNT = 4'h4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic start;
    logic stop;
    logic set_mask;
    logic set_val;
    logic set_cnt;
  } cmd_dec_t;

  // At most one field is set, so callers may use unique case.
  function automatic cmd_dec_t cmd_decode(
    input logic        valid,
    input logic [31:0] word
  );
    cmd_dec_t d;
    d          = '0;
    d.start    = valid && (word == CMD_START);
    d.stop     = valid && (word == CMD_STOP);
    d.set_mask = valid && (word[31:28] == OP_SET_MASK);
    d.set_val  = valid && (word[31:28] == OP_SET_VAL);
    d.set_cnt  = valid && (word[31:28] == OP_SET_COUNT);
    return d;
  endfunction

endpackage

// File: rtl/capture_ctrl_trig_cmp.sv
// Combinational trigger comparator.
// Ports: sample/mask/val (16b), valid in; hit out.
module trig_cmp (
  input  logic [15:0] sample,
  input  logic [15:0] mask,
  input  logic [15:0] val,
  input  logic        valid,
  output logic        hit
);

  assign hit = valid && (((sample ^ val) & mask) == 16'h0);

endmodule

// File: rtl/capture_ctrl.sv
// Sample capture controller: host commands, trigger, FIFO writes.
// Ports: cmd_valid/cmd_data, sample_i/sample_valid, fifo_full in;
// fifo_wr_n/fifo_data, run_en, done, overflow, state_o out.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int CNT_LEN  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [DATA_LEN-1:0] cmd_data,
  input  logic [DATA_LEN-1:0] sample_i,
  input  logic                sample_valid,
  input  logic                fifo_full,
  output logic                fifo_wr_n,
  output logic [DATA_LEN-1:0] fifo_data,
  output logic                run_en,
  output logic                done,
  output logic                overflow,
  output logic [1:0]          state_o
);

  logic [1:0]          state_q, state_d;
  logic [CNT_LEN-1:0]  cnt_q, cnt_d;
  logic [CNT_LEN-1:0]  target_q, target_d;
  logic [15:0]         mask_q, mask_d;
  logic [15:0]         val_q, val_d;
  logic                ovf_q, ovf_d;
  logic                wr_n_q, wr_n_d;
  logic [DATA_LEN-1:0] data_q, data_d;

  cmd_dec_t           dec;
  logic               hit;
  logic               take;
  logic [CNT_LEN-1:0] cnt_sat;

  assign dec = cmd_decode(cmd_valid, cmd_data[31:0]);

  trig_cmp u_trig (
    .sample (sample_i[15:0]),
    .mask   (mask_q),
    .val    (val_q),
    .valid  (sample_valid),
    .hit    (hit)
  );

  // Free-running capture must not wrap back to zero.
  assign cnt_sat = (cnt_q == '1) ? cnt_q
                 : cnt_q + CNT_LEN'(1);

  // A sample is taken on a trigger hit while armed, or any
  // valid sample while capturing. STOP always overrides.
  always_comb begin
    take = 1'b0;
    if (!dec.stop) begin
      unique case (state_q)
        ST_ARMED:   take = hit;
        ST_CAPTURE: take = sample_valid;
        default:    take = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    mask_d   = mask_q;
    val_d    = val_q;
    ovf_d    = ovf_q;
    wr_n_d   = 1'b1;
    data_d   = data_q;

    if (dec.stop) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE ||
                 state_q == ST_DONE) begin
      unique case (1'b1)
        dec.start: begin
          state_d = ST_ARMED;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
        dec.set_mask: mask_d = cmd_data[15:0];
        dec.set_val:  val_d  = cmd_data[15:0];
        dec.set_cnt:
          target_d = CNT_LEN'(cmd_data[23:0]);
        default: ;
      endcase
    end

    if (take) begin
      if (state_q == ST_ARMED)
        state_d = ST_CAPTURE;
      if (!fifo_full) begin
        wr_n_d = 1'b0;
        data_d = sample_i;
        cnt_d  = cnt_sat;
        // Last write and DONE land on the same edge.
        if (target_q != '0 && cnt_sat == target_q)
          state_d = ST_DONE;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      mask_q   <= '0;
      val_q    <= '0;
      ovf_q    <= 1'b0;
      wr_n_q   <= 1'b1;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      val_q    <= val_d;
      ovf_q    <= ovf_d;
      wr_n_q   <= wr_n_d;
      data_q   <= data_d;
    end
  end

  assign fifo_wr_n = wr_n_q;
  assign fifo_data = data_q;
  assign overflow  = ovf_q;
  assign state_o   = state_q;
  assign done      = (state_q == ST_DONE);
  assign run_en    = (state_q == ST_ARMED) ||
                     (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl.
// Expected FIFO words queued on drive, popped on write.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic [31:0] sample_i;
  logic        sample_valid;
  logic        fifo_full;
  logic        fifo_wr_n;
  logic [31:0] fifo_data;
  logic        run_en;
  logic        done;
  logic        overflow;
  logic [1:0]  state_o;

  int n_chk;
  int n_fail;
  int wr_cnt;
  int base;
  logic [31:0] sb[$];

  capture_ctrl #(.DATA_LEN(32), .CNT_LEN(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .sample_i     (sample_i),
    .sample_valid (sample_valid),
    .fifo_full    (fifo_full),
    .fifo_wr_n    (fifo_wr_n),
    .fifo_data    (fifo_data),
    .run_en       (run_en),
    .done         (done),
    .overflow     (overflow),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Outputs are stable across the low phase; sample there.
  always @(negedge clk) begin
    if (rst_n && !fifo_wr_n) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        chk("wr_unexpected_q", 64'(sb.size()), 64'd1);
      end else begin
        chk("wr_data", 64'(fifo_data), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [31:0] w);
    cmd_valid = 1'b1;
    cmd_data  = w;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  task automatic smp(
    input logic [31:0] w,
    input logic        full,
    input logic        exp_wr
  );
    sample_i     = w;
    sample_valid = 1'b1;
    fifo_full    = full;
    if (exp_wr) sb.push_back(w);
    tick();
    sample_valid = 1'b0;
    fifo_full    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] w;
    n_chk = 0; n_fail = 0; wr_cnt = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    sample_i = '0; sample_valid = 1'b0; fifo_full = 1'b0;
    idle(2);
    chk("rst_state", 64'(state_o), 64'(ST_IDLE));
    chk("rst_wr_n", 64'(fifo_wr_n), 64'd1);
    chk("rst_data", 64'(fifo_data), 64'd0);
    chk("rst_run_en", 64'(run_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Masked trigger, count 4
    base = wr_cnt;
    cmd(32'h2000_00FF);
    cmd(32'h3000_00A5);
    cmd(32'h4000_0004);
    cmd(CMD_START);
    chk("t1_armed", 64'(state_o), 64'(ST_ARMED));
    chk("t1_run_en", 64'(run_en), 64'd1);
    smp(32'h0000_0011, 1'b0, 1'b0);
    chk("t1_nohit", 64'(state_o), 64'(ST_ARMED));
    chk("t1_nohit_wr", 64'(fifo_wr_n), 64'd1);
    smp(32'h1234_00A5, 1'b0, 1'b1);
    chk("t1_capture", 64'(state_o), 64'(ST_CAPTURE));
    smp(32'h0BAD_0001, 1'b0, 1'b1);
    smp(32'h0BAD_0002, 1'b0, 1'b1);
    chk("t1_not_done", 64'(done), 64'd0);
    smp(32'h0BAD_0003, 1'b0, 1'b1);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_run_off", 64'(run_en), 64'd0);
    smp(32'h0BAD_0004, 1'b0, 1'b0);
    idle(2);
    chk("t1_writes", 64'(wr_cnt - base), 64'd4);

    // Free-running capture, stop after 10
    base = wr_cnt;
    cmd(CMD_STOP);
    chk("t2_idle", 64'(state_o), 64'(ST_IDLE));
    cmd(32'h2000_0000);
    cmd(32'h4000_0000);
    cmd(CMD_START);
    chk("t2_done_clr", 64'(done), 64'd0);
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      smp(w, 1'b0, 1'b1);
    end
    chk("t2_still_cap", 64'(state_o), 64'(ST_CAPTURE));
    cmd(CMD_STOP);
    chk("t2_stop", 64'(state_o), 64'(ST_IDLE));
    smp(32'h5555_AAAA, 1'b0, 1'b0);
    idle(2);
    chk("t2_writes", 64'(wr_cnt - base), 64'd10);

    // Count 8 with samples 3-4 dropped on full
    base = wr_cnt;
    cmd(32'h4000_0008);
    cmd(CMD_START);
    for (int i = 1; i <= 10; i++) begin
      w = 32'hC000_0000 + 32'(i);
      smp(w, (i == 3 || i == 4), !(i == 3 || i == 4));
      if (i == 9)
        chk("t3_cap9", 64'(state_o), 64'(ST_CAPTURE));
    end
    chk("t3_done", 64'(state_o), 64'(ST_DONE));
    chk("t3_ovf", 64'(overflow), 64'd1);
    idle(2);
    chk("t3_writes", 64'(wr_cnt - base), 64'd8);

    // SET_COUNT during capture is ignored
    base = wr_cnt;
    cmd(CMD_STOP);
    cmd(32'h4000_0004);
    cmd(CMD_START);
    chk("t4_ovf_clr", 64'(overflow), 64'd0);
    smp(32'hD000_0001, 1'b0, 1'b1);
    cmd(32'h4000_0002);
    smp(32'hD000_0002, 1'b0, 1'b1);
    chk("t4_ignored", 64'(state_o), 64'(ST_CAPTURE));
    smp(32'hD000_0003, 1'b0, 1'b1);
    smp(32'hD000_0004, 1'b0, 1'b1);
    chk("t4_done", 64'(state_o), 64'(ST_DONE));
    idle(2);
    chk("t4_writes", 64'(wr_cnt - base), 64'd4);

    // STOP beats a same-cycle sample
    base = wr_cnt;
    cmd(32'h4000_0000);
    cmd(CMD_START);
    smp(32'hE000_0001, 1'b0, 1'b1);
    cmd_valid    = 1'b1;
    cmd_data     = CMD_STOP;
    sample_valid = 1'b1;
    sample_i     = 32'hE000_0002;
    tick();
    cmd_valid    = 1'b0;
    sample_valid = 1'b0;
    chk("t5_idle", 64'(state_o), 64'(ST_IDLE));
    chk("t5_no_wr", 64'(fifo_wr_n), 64'd1);
    idle(2);
    chk("t5_writes", 64'(wr_cnt - base), 64'd1);

    // Reset mid-capture kills the pending strobe
    base = wr_cnt;
    cmd(CMD_START);
    smp(32'hF000_0001, 1'b0, 1'b1);
    smp(32'hF000_0002, 1'b0, 1'b0);
    chk("t6_wr_pend", 64'(fifo_wr_n), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_n", 64'(fifo_wr_n), 64'd1);
    chk("t6_rst_data", 64'(fifo_data), 64'd0);
    chk("t6_rst_state", 64'(state_o), 64'(ST_IDLE));
    chk("t6_rst_run", 64'(run_en), 64'd0);
    sample_valid = 1'b1;
    sample_i     = 32'hF000_0003;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    sample_valid = 1'b0;
    chk("t6_idle", 64'(state_o), 64'(ST_IDLE));
    chk("t6_writes", 64'(wr_cnt - base), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
